// File: rtl/bus_txn_ctrl.sv
// Control-side initiator for the shared 8-bit data bus (source 2'b11).
// Optional idle-bus watchdog: define BUS_TXN_CTRL_TIMEOUT_EN.
module bus_txn_ctrl #(
   parameter int LEN_W          = 8,
   parameter int GRANT_CYCLES   = 3,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   input  logic [1:0]       req_src,
   input  logic [1:0]       req_dest,
   input  logic [LEN_W-1:0] req_len,
   output logic             req_ready,
   output logic             send_valid,
   output logic [7:0]       send_data,
   input  logic             send_ready,
   input  logic             bus_valid,
   output logic             ack,
   output logic             busy,
   output logic             err
);

   localparam int GW = (GRANT_CYCLES > 1) ? $clog2(GRANT_CYCLES) : 1;

   typedef enum logic [2:0] {
      IDLE, HDR, GRANT, XFER, ACK
   } state_t;

   state_t           state, state_n;
   logic [LEN_W-1:0] len_q, len_n;
   logic [LEN_W-1:0] beat_q, beat_n;
   logic [GW-1:0]    gcnt_q, gcnt_n;
   logic             sv_n, ack_n, busy_n, err_n;
   logic [7:0]       sd_n;
   logic             bv;

   // A floating monitor line reads as an idle bus.
   assign bv        = (bus_valid === 1'b1);
   assign req_ready = (state == IDLE);

`ifdef BUS_TXN_CTRL_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] idle_q, idle_n;
   logic          tmo;

   // Watchdog: consecutive idle-bus cycles while the bus is owned.
   always_comb begin
      idle_n = idle_q;
      tmo    = 1'b0;
      if (state == GRANT || state == XFER) begin
         if (bv)
            idle_n = '0;
         else if (idle_q == TW'(TIMEOUT_CYCLES - 1))
            tmo = 1'b1;
         else
            idle_n = idle_q + TW'(1);
      end
      if (state == ACK)
         idle_n = '0;
   end

   // Watchdog counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         idle_q <= '0;
      else
         idle_q <= idle_n;
   end
`endif

   // Next-state and registered-output logic.
   always_comb begin
      state_n = state;
      len_n   = len_q;
      beat_n  = beat_q;
      gcnt_n  = gcnt_q;
      sv_n    = send_valid;
      sd_n    = send_data;
      ack_n   = 1'b0;
      busy_n  = busy;
      err_n   = 1'b0;
      unique case (state)
         IDLE: begin
            if (req_valid) begin
               if (req_src == 2'b11) begin
                  err_n = 1'b1;
               end else begin
                  len_n   = req_len;
                  busy_n  = 1'b1;
                  sv_n    = 1'b1;
                  sd_n    = {2'b00, req_dest, req_src, 2'b00};
                  state_n = HDR;
               end
            end
         end
         HDR: begin
            if (send_ready) begin
               sv_n = 1'b0;
               sd_n = '0;
               if (len_q == '0) begin
                  ack_n   = 1'b1;
                  state_n = ACK;
               end else begin
                  gcnt_n  = '0;
                  state_n = GRANT;
               end
            end
         end
         GRANT: begin
            if (gcnt_q == GW'(GRANT_CYCLES - 1)) begin
               gcnt_n  = '0;
               state_n = XFER;
            end else begin
               gcnt_n = gcnt_q + GW'(1);
            end
         end
         XFER: begin
            if (bv) begin
               if (beat_q == len_q - LEN_W'(1)) begin
                  ack_n   = 1'b1;
                  state_n = ACK;
               end else begin
                  beat_n = beat_q + LEN_W'(1);
               end
            end
         end
         ACK: begin
            busy_n  = 1'b0;
            beat_n  = '0;
            gcnt_n  = '0;
            len_n   = '0;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
`ifdef BUS_TXN_CTRL_TIMEOUT_EN
      if (tmo) begin
         err_n   = 1'b1;
         ack_n   = 1'b1;
         state_n = ACK;
      end
`endif
   end

   // State, counters and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         len_q      <= '0;
         beat_q     <= '0;
         gcnt_q     <= '0;
         send_valid <= 1'b0;
         send_data  <= '0;
         ack        <= 1'b0;
         busy       <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_n;
         len_q      <= len_n;
         beat_q     <= beat_n;
         gcnt_q     <= gcnt_n;
         send_valid <= sv_n;
         send_data  <= sd_n;
         ack        <= ack_n;
         busy       <= busy_n;
         err        <= err_n;
      end
   end

endmodule

// File: tb/tb_bus_txn_ctrl.sv
// Bench for bus_txn_ctrl: directed cases plus randomized transactions
// checked against a transaction-timeline model.
module tb_bus_txn_ctrl;

`ifdef BUS_TXN_CTRL_TIMEOUT_EN
   localparam int TO = 8;
`else
   localparam int TO = 64;
`endif
   localparam int GC = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid;
   logic [1:0] req_src;
   logic [1:0] req_dest;
   logic [7:0] req_len;
   logic       req_ready;
   logic       send_valid;
   logic [7:0] send_data;
   logic       send_ready;
   logic       bus_valid;
   logic       ack;
   logic       busy;
   logic       err;

   int ncmp = 0;
   int nbad = 0;

   bus_txn_ctrl #(
      .LEN_W(8),
      .GRANT_CYCLES(GC),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req_valid(req_valid),
      .req_src(req_src),
      .req_dest(req_dest),
      .req_len(req_len),
      .req_ready(req_ready),
      .send_valid(send_valid),
      .send_data(send_data),
      .send_ready(send_ready),
      .bus_valid(bus_valid),
      .ack(ack),
      .busy(busy),
      .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nbad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_chk(input string tag);
      chk({tag, "_rdy"}, req_ready, 8'd1);
      chk({tag, "_busy"}, busy, 8'd0);
      chk({tag, "_ack"}, ack, 8'd0);
      chk({tag, "_sv"}, send_valid, 8'd0);
   endtask

   // One full transaction: header (with optional stall), grant window
   // with ignored bus traffic, len payload beats, one-cycle ack.
   task automatic run_txn(input logic [1:0] s, input logic [1:0] d,
                          input logic [7:0] l, input int stall,
                          input bit gaps);
      logic [7:0] hdr;
      int beats;
      int zrun;
      hdr = {2'b00, d, s, 2'b00};
      chk("acc_rdy", req_ready, 8'd1);
      req_valid  = 1'b1;
      req_src    = s;
      req_dest   = d;
      req_len    = l;
      send_ready = 1'b0;
      bus_valid  = 1'b0;
      cyc();
      req_valid = 1'b0;
      for (int k = 0; k <= stall; k++) begin
         chk("hdr_sv", send_valid, 8'd1);
         chk("hdr_data", send_data, hdr);
         chk("hdr_busy", busy, 8'd1);
         chk("hdr_rdy", req_ready, 8'd0);
         send_ready = (k == stall);
         bus_valid  = 1'($urandom % 2);
         cyc();
      end
      send_ready = 1'b0;
      if (l == 8'd0) begin
         bus_valid = 1'b0;
         chk("ack0", ack, 8'd1);
         chk("ack0_busy", busy, 8'd1);
         chk("ack0_sv", send_valid, 8'd0);
         cyc();
         idle_chk("post0");
         return;
      end
      zrun = 0;
      for (int g = 0; g < GC; g++) begin
         chk("gnt_sv", send_valid, 8'd0);
         chk("gnt_ack", ack, 8'd0);
         chk("gnt_busy", busy, 8'd1);
         chk("gnt_err", err, 8'd0);
         bus_valid = 1'($urandom % 2);
         zrun = bus_valid ? 0 : zrun + 1;
         cyc();
      end
      beats = 0;
      while (beats < int'(l)) begin
         chk("xfr_ack", ack, 8'd0);
         chk("xfr_busy", busy, 8'd1);
         if (!gaps || zrun >= 3)
            bus_valid = 1'b1;
         else
            bus_valid = 1'($urandom % 2);
         if (bus_valid) begin
            beats++;
            zrun = 0;
         end else begin
            zrun++;
         end
         cyc();
      end
      bus_valid = 1'b0;
      chk("ack", ack, 8'd1);
      chk("ack_busy", busy, 8'd1);
      chk("ack_err", err, 8'd0);
      cyc();
      idle_chk("post");
   endtask

   // Accept a request, pass the header, sit out grant with bus_valid=1.
   task automatic start_to_xfer(input logic [1:0] s, input logic [1:0] d,
                                input logic [7:0] l);
      req_valid  = 1'b1;
      req_src    = s;
      req_dest   = d;
      req_len    = l;
      send_ready = 1'b1;
      bus_valid  = 1'b0;
      cyc();
      req_valid = 1'b0;
      chk("sx_data", send_data, {2'b00, d, s, 2'b00});
      cyc();
      send_ready = 1'b0;
      bus_valid  = 1'b1;
      for (int g = 0; g < GC; g++) begin
         chk("sx_busy", busy, 8'd1);
         cyc();
      end
   endtask

   task automatic mid_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_ack", ack, 8'd0);
      chk("rst_busy", busy, 8'd0);
      chk("rst_sv", send_valid, 8'd0);
      chk("rst_rdy", req_ready, 8'd1);
      @(negedge clk);
      rst_n     = 1'b1;
      bus_valid = 1'b0;
      cyc();
      idle_chk("rst_rel");
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_src    = '0;
      req_dest   = '0;
      req_len    = '0;
      send_ready = 1'b0;
      bus_valid  = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_rdy", req_ready, 8'd1);
      chk("reset_sv", send_valid, 8'd0);
      chk("reset_sd", send_data, 8'd0);
      chk("reset_ack", ack, 8'd0);
      chk("reset_busy", busy, 8'd0);
      chk("reset_err", err, 8'd0);
      rst_n = 1'b1;
      cyc();
      idle_chk("start");

      run_txn(2'd1, 2'd2, 8'd4, 0, 1'b0);
      run_txn(2'd2, 2'd0, 8'd0, 0, 1'b1);
      run_txn(2'd1, 2'd2, 8'd4, 5, 1'b1);

      req_valid = 1'b1;
      req_src   = 2'b11;
      req_dest  = 2'd1;
      req_len   = 8'd3;
      cyc();
      req_valid = 1'b0;
      chk("ill_err", err, 8'd1);
      chk("ill_busy", busy, 8'd0);
      chk("ill_sv", send_valid, 8'd0);
      chk("ill_rdy", req_ready, 8'd1);
      cyc();
      chk("ill_err_end", err, 8'd0);
      chk("ill_sv2", send_valid, 8'd0);

      for (int t = 0; t < 20; t++) begin
         run_txn(2'($urandom % 3), 2'($urandom % 4),
                 8'($urandom % 9), int'($urandom % 4), 1'b1);
      end
      run_txn(2'd0, 2'd3, 8'd255, 1, 1'b1);

      start_to_xfer(2'd1, 2'd2, 8'd4);
      bus_valid = 1'b1;
      repeat (2) begin
         chk("to_beat_ack", ack, 8'd0);
         cyc();
      end
      bus_valid = 1'b0;
`ifdef BUS_TXN_CTRL_TIMEOUT_EN
      for (int i = 0; i < TO; i++) begin
         chk("to_wait_ack", ack, 8'd0);
         chk("to_wait_err", err, 8'd0);
         cyc();
      end
      chk("to_ack", ack, 8'd1);
      chk("to_err", err, 8'd1);
      chk("to_busy", busy, 8'd1);
      cyc();
      chk("to_err_end", err, 8'd0);
      idle_chk("to_post");
      start_to_xfer(2'd0, 2'd1, 8'd3);
      bus_valid = 1'b1;
      cyc();
      mid_reset();
`else
      for (int i = 0; i < 80; i++) begin
         chk("nto_ack", ack, 8'd0);
         chk("nto_err", err, 8'd0);
         chk("nto_busy", busy, 8'd1);
         cyc();
      end
      mid_reset();
`endif

      run_txn(2'd2, 2'd1, 8'd2, 0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
      $finish;
   end

endmodule
